// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state type, default pattern and window compare for seq_detect_param
//   IDLE/FILL/DETECT state enum, DEF_PATTERN/DEF_LEN (the legacy 1101101 detector),
//   pat_match(): compares the low len bits of a window against a pattern, skipping masked bits.
package seq_detect_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;
  localparam logic [6:0] DEF_PATTERN = 7'b1101101;
  localparam int DEF_LEN = 7;
  localparam int CMP_W = 64;
  function automatic logic pat_match(
    input logic [CMP_W-1:0] pattern,
    input logic [CMP_W-1:0] window,
    input int len,
    input logic [CMP_W-1:0] mask
  );
    logic [CMP_W-1:0] in_len;
    in_len = ~({CMP_W{1'b1}} << len);
    return ((pattern ^ window) & ~mask & in_len) == '0;
  endfunction
endpackage

// File: rtl/seq_detect_cnt.sv
// seq_detect_cnt: saturating match counter, clear has priority over increment
//   clk, rst_n (async active-low), clr (sync clear), inc (count one), cnt (count value)
module seq_detect_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector with overlap modes
//   i_clk/i_rst_n: clock, async active-low reset
//   i_cfg_load, i_pattern, i_len, i_overlap: configuration latch (i_mask too with SEQ_DETECT_MASK_EN)
//   i_valid, i_data: qualified serial stream; i_cnt_clr: clears o_match_cnt
//   o_find: registered match pulse; o_match_cnt: saturating count;
//   o_cfg_err: last length illegal; o_armed: detector in FILL or DETECT
//   Optional macro SEQ_DETECT_MASK_EN adds per-bit wildcard mask i_mask.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [MAX_LEN-1:0] i_mask,
`endif
  input  logic               i_valid,
  input  logic               i_data,
  input  logic               i_cnt_clr,
  output logic               o_find,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err,
  output logic               o_armed
);
  state_t state;
  logic [MAX_LEN-1:0] sreg, pat, mask, sreg_nxt;
  logic [LEN_W-1:0] len, fill, fill_nxt;
  logic ovl, hit, legal;
`ifdef SEQ_DETECT_MASK_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) mask <= '0;
    else if (i_cfg_load) mask <= i_mask;
`else
  assign mask = '0;
`endif
  always_comb begin
    sreg_nxt = {sreg[MAX_LEN-2:0], i_data};
    fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    legal = i_len != '0 && i_len <= LEN_W'(MAX_LEN);
    // a load in the same cycle suppresses any completing bit
    hit = i_valid && !i_cfg_load && state != IDLE && fill_nxt >= len &&
          pat_match(CMP_W'(pat), CMP_W'(sreg_nxt), int'(len), CMP_W'(mask));
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      sreg <= '0;
      fill <= '0;
      pat <= '0;
      len <= '0;
      ovl <= 1'b0;
      o_find <= 1'b0;
      o_cfg_err <= 1'b0;
    end else if (i_cfg_load) begin
      pat <= i_pattern;
      len <= i_len;
      ovl <= i_overlap;
      sreg <= '0;
      fill <= '0;
      o_find <= 1'b0;
      o_cfg_err <= !legal;
      state <= legal ? FILL : IDLE;
    end else begin
      o_find <= hit;
      if (i_valid && state != IDLE) begin
        sreg <= sreg_nxt;
        // non-overlapping mode restarts the fill so matched bits are never reused
        fill <= (hit && !ovl) ? '0 : fill_nxt;
        state <= (hit && !ovl) ? FILL : (fill_nxt >= len) ? DETECT : FILL;
      end
    end
  assign o_armed = state != IDLE;
  seq_detect_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .clr(i_cnt_clr),
    .inc(hit),
    .cnt(o_match_cnt)
  );
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed bench with a bit-history model for seq_detect_param (8-bit and 2-bit counters)
module tb_seq_detect_param;
  import seq_detect_pkg::*;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);
  logic i_clk = 0, i_rst_n = 0, i_cfg_load = 0, i_overlap = 0, i_valid = 0, i_data = 0, i_cnt_clr = 0;
  logic [ML-1:0] i_pattern = '0;
  logic [LW-1:0] i_len = '0;
  logic find_a, find_b, err_a, err_b, armed_a, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int n_cmp = 0, n_err = 0, dut_finds = 0, base = 0;
  bit chk_en = 0;
  bit m_find, m_err, m_armed, m_ovl, e_find, e_err, e_armed;
  int m_len, m_cnt8, m_cnt2, e_cnt8, e_cnt2;
  logic [ML-1:0] m_pat;
  bit hist[$];
  int fpos[$];
  always #5 i_clk = ~i_clk;
  seq_detect_param #(.MAX_LEN(ML), .CNT_W(8)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_load(i_cfg_load), .i_pattern(i_pattern),
    .i_len(i_len), .i_overlap(i_overlap),
`ifdef SEQ_DETECT_MASK_EN
    .i_mask('0),
`endif
    .i_valid(i_valid), .i_data(i_data), .i_cnt_clr(i_cnt_clr),
    .o_find(find_a), .o_match_cnt(cnt_a), .o_cfg_err(err_a), .o_armed(armed_a)
  );
  seq_detect_param #(.MAX_LEN(ML), .CNT_W(2)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_load(i_cfg_load), .i_pattern(i_pattern),
    .i_len(i_len), .i_overlap(i_overlap),
`ifdef SEQ_DETECT_MASK_EN
    .i_mask('0),
`endif
    .i_valid(i_valid), .i_data(i_data), .i_cnt_clr(i_cnt_clr),
    .o_find(find_b), .o_match_cnt(cnt_b), .o_cfg_err(err_b), .o_armed(armed_b)
  );
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_find = 0; m_err = 0; m_armed = 0; m_ovl = 0; m_len = 0; m_pat = '0;
    m_cnt8 = 0; m_cnt2 = 0;
    hist.delete();
  endtask
  // model: keep the bits received since the last load (or last non-overlapping match)
  // and compare the newest len of them directly against the pattern
  task automatic model_step();
    bit hit;
    hit = 0;
    if (i_cfg_load) begin
      m_pat = i_pattern; m_len = int'(i_len); m_ovl = i_overlap;
      hist.delete();
      m_err = (m_len < 1 || m_len > ML);
      m_armed = !m_err;
    end else if (m_armed && i_valid) begin
      hist.push_back(i_data);
      if (hist.size() > ML) void'(hist.pop_front());
      if (hist.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++) if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 0;
      end
      if (hit && !m_ovl) hist.delete();
    end
    m_find = hit;
    if (i_cnt_clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask
  always @(posedge i_clk or negedge i_rst_n) begin
    e_find <= m_find; e_err <= m_err; e_armed <= m_armed; e_cnt8 <= m_cnt8; e_cnt2 <= m_cnt2;
  end
  always @(negedge i_clk) if (chk_en) begin
    if (find_a) dut_finds++;
    check("find_a", int'(find_a), int'(e_find));
    check("find_b", int'(find_b), int'(e_find));
    check("cnt_a", int'(cnt_a), e_cnt8);
    check("cnt_b", int'(cnt_b), e_cnt2);
    check("err_a", int'(err_a), int'(e_err));
    check("armed_a", int'(armed_a), int'(e_armed));
    check("armed_b", int'(armed_b), int'(e_armed));
  end
  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic load(input logic [ML-1:0] p, input int l, input bit o);
    i_pattern = p; i_len = LW'(l); i_overlap = o;
    i_cfg_load = 1; i_valid = 1; i_data = 1;
    tick();
    i_cfg_load = 0; i_valid = 0;
  endtask
  task automatic clear();
    i_cnt_clr = 1;
    tick();
    i_cnt_clr = 0;
  endtask
  task automatic stream(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = 1; i <= n; i++) begin
      i_valid = 1; i_data = bits[n - i];
      tick();
      if (m_find) fpos.push_back(i);
      if (gaps) begin
        i_valid = 0; i_data = 1;
        tick();
      end
    end
    i_valid = 0; i_data = 0;
    tick();
  endtask
  function automatic int pos(input int i);
    return (i < fpos.size()) ? fpos[i] : -1;
  endfunction
  task automatic start(input logic [ML-1:0] p, input int l, input bit o);
    clear();
    fpos.delete();
    load(p, l, o);
    base = dut_finds;
  endtask
  task automatic reset_now();
    i_cfg_load = 0; i_valid = 0; i_cnt_clr = 0;
    model_reset();
    i_rst_n = 0;
    #1;
    check("rst_find", int'(find_a), 0);
    check("rst_armed", int'(armed_a), 0);
    check("rst_cnt", int'(cnt_a), 0);
    check("rst_err", int'(err_a), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask
  logic [31:0] s;
  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("init_find", int'(find_a), 0);
    check("init_armed", int'(armed_a), 0);
    check("init_cnt", int'(cnt_a), 0);
    check("init_err", int'(err_a), 0);
    i_rst_n = 1;
    chk_en = 1;
    s = 32'b0000001101101101101111111;
    start(ML'(DEF_PATTERN), DEF_LEN, 1);
    stream(s, 25, 0);
    check("ovl_model_n", fpos.size(), 3);
    check("ovl_pos0", pos(0), 13);
    check("ovl_pos1", pos(1), 16);
    check("ovl_pos2", pos(2), 19);
    check("ovl_dut_finds", dut_finds - base, 3);
    check("ovl_cnt", int'(cnt_a), 3);
    start(ML'(DEF_PATTERN), DEF_LEN, 0);
    stream(s, 25, 0);
    check("novl_model_n", fpos.size(), 1);
    check("novl_pos0", pos(0), 13);
    check("novl_dut_finds", dut_finds - base, 1);
    check("novl_cnt", int'(cnt_a), 1);
    start(ML'(1), 1, 1);
    stream(32'b1011, 4, 1);
    check("len1_model_n", fpos.size(), 3);
    check("len1_pos", pos(0) * 100 + pos(1) * 10 + pos(2), 134);
    check("len1_dut_finds", dut_finds - base, 3);
    check("len1_cnt", int'(cnt_a), 3);
    start(ML'(DEF_PATTERN), DEF_LEN, 1);
    load(ML'(DEF_PATTERN), 0, 1);
    check("bad0_err", int'(err_a), 1);
    check("bad0_armed", int'(armed_a), 0);
    stream(s, 25, 0);
    check("bad0_dut_finds", dut_finds - base, 0);
    load(ML'(DEF_PATTERN), 17, 1);
    check("bad17_err", int'(err_a), 1);
    load(ML'(DEF_PATTERN), DEF_LEN, 1);
    check("reload_err", int'(err_a), 0);
    check("reload_armed", int'(armed_a), 1);
    stream(32'b1101101, 7, 0);
    check("reload_dut_finds", dut_finds - base, 1);
    check("reload_cnt", int'(cnt_a), 1);
    start(ML'(3), 2, 1);
    stream(32'b111111, 6, 0);
    check("sat_cnt8", int'(cnt_a), 5);
    check("sat_cnt2", int'(cnt_b), 3);
    i_cnt_clr = 1; i_valid = 1; i_data = 1;
    tick();
    i_cnt_clr = 0; i_valid = 0;
    tick();
    check("clrwin_finds", dut_finds - base, 6);
    check("clrwin_cnt8", int'(cnt_a), 0);
    check("clrwin_cnt2", int'(cnt_b), 0);
    start(ML'(DEF_PATTERN), DEF_LEN, 1);
    stream(32'b11011, 5, 0);
    reset_now();
    stream(32'b01, 2, 0);
    check("midrst_finds", dut_finds - base, 0);
    check("midrst_armed", int'(armed_a), 0);
    start(ML'(DEF_PATTERN), DEF_LEN, 1);
    stream(32'b11011, 5, 0);
    load(ML'(DEF_PATTERN), DEF_LEN, 1);
    stream(32'b01, 2, 0);
    check("midload_prefix", dut_finds - base, 0);
    fpos.delete();
    stream(32'b1101101, 7, 0);
    check("midload_model_pos", pos(0), 7);
    check("midload_finds", dut_finds - base, 1);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
